// File: rtl/mem_queued_pkg.sv
// rtl/mem_queued_pkg.sv - shared types and constants for the queued memory model
package mem_queued_pkg;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int LAT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic          read;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// rtl/mem_req_fifo.sv - synchronous request FIFO; full is judged before the push
module mem_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 42
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers are power-of-two wide, so they wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_queued.sv
// rtl/mem_queued.sv - in-order queued memory with address-dependent service latency
module mem_queued #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int QDEPTH     = 4,
  parameter int FAST_LIMIT = 64,
  parameter int FAST_LAT   = 2,
  parameter int SLOW_LAT   = 8,
  parameter int ERR_BASE   = 192
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_req,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_ready,
  output logic          mem_ack,
  output logic          mem_err,
  output logic [DW-1:0] mem_data
);

  import mem_queued_pkg::*;

  req_t             push_req;
  req_t             head;
  req_t             cur_q;
  req_t             cur_d;
  state_t           state_q;
  state_t           state_d;
  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;
  logic [LAT_W-1:0] lat;
  logic             full;
  logic             empty;
  logic             pop;
  logic             wr_only;
  logic             rd_ok;
  logic [DW-1:0]    array [2**AW];

  assign push_req  = '{read: mem_read, write: mem_write, addr: mem_addr, wdata: mem_wdata};
  assign mem_ready = !full;

  mem_req_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH ($bits(req_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mem_req),
    .push_data (push_req),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  assign lat = (int'(head.addr) < FAST_LIMIT) ? LAT_W'(FAST_LAT) : LAT_W'(SLOW_LAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
    end
  end

  // The pop edge counts as the first latency cycle and RESP as the last,
  // so WAIT holds for lat-1 cycles and is skipped entirely when lat is 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          cur_d = head;
          if (lat == LAT_W'(1)) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = lat - LAT_W'(2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - LAT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr_only  = cur_q.write && !cur_q.read;
  assign rd_ok    = cur_q.read && !cur_q.write && (int'(cur_q.addr) < ERR_BASE);
  assign mem_ack  = (state_q == RESP);
  assign mem_err  = mem_ack && !wr_only && !rd_ok;
  assign mem_data = (mem_ack && rd_ok) ? array[cur_q.addr] : '0;

  // A reset landing on the RESP edge drops the write along with the ack.
  always_ff @(posedge clk) begin
    if (!rst && mem_ack && wr_only) array[cur_q.addr] <= cur_q.wdata;
  end

endmodule

// File: tb/tb_mem_queued.sv
// tb/tb_mem_queued.sv - randomized self-checking bench with an in-order transaction model
module tb_mem_queued;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int FAST_LIMIT = 64;
  localparam int FAST_LAT = 2;
  localparam int SLOW_LAT = 8;
  localparam int ERR_BASE = 192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          mem_ready;
  logic          mem_ack;
  logic          mem_err;
  logic [DW-1:0] mem_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_ack = 0;
  bit started = 0;
  bit saw_not_ready = 0;

  typedef struct {
    int            ack_edge;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t          pend[$];
  logic [DW-1:0] model_mem [256];

  mem_queued dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_ack   (mem_ack),
    .mem_err   (mem_err),
    .mem_data  (mem_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc + 1);
    end
  endtask

  // Monitor: at each negedge, the upcoming edge index is cyc+1.
  always @(negedge clk) begin : mon
    exp_t          e;
    logic [DW-1:0] xd;
    logic          xe;
    int            n;
    int            lat;
    int            pop_edge;
    if (rst) begin
      pend.delete();
      last_ack = 0;
    end else if (started) begin
      if (!mem_ready) saw_not_ready = 1;
      if (mem_ack) begin
        if (pend.size() == 0) begin
          check_eq("unexpected_ack", 1, 0);
        end else begin
          e  = pend.pop_front();
          xe = 1'b1;
          xd = '0;
          if (e.wr && !e.rd) begin
            xe = 1'b0;
            model_mem[e.addr] = e.wdata;
          end else if (e.rd && !e.wr && int'(e.addr) < ERR_BASE) begin
            xe = 1'b0;
            xd = model_mem[e.addr];
          end
          check_eq("ack_edge", cyc + 1, e.ack_edge);
          check_eq("ack_err", mem_err, xe);
          check_eq("ack_data", mem_data, xd);
        end
      end else begin
        check_eq("idle_err", mem_err, 0);
        check_eq("idle_data", mem_data, 0);
        if (pend.size() > 0 && pend[0].ack_edge <= cyc + 1) begin
          check_eq("ack_missing", cyc + 1, pend[0].ack_edge);
          void'(pend.pop_front());
        end
      end
      if (mem_req && mem_ready) begin
        n        = cyc + 1;
        lat      = (int'(mem_addr) < FAST_LIMIT) ? FAST_LAT : SLOW_LAT;
        pop_edge = (n + 1 > last_ack + 1) ? n + 1 : last_ack + 1;
        e.ack_edge = pop_edge + lat;
        e.rd    = mem_read;
        e.wr    = mem_write;
        e.addr  = mem_addr;
        e.wdata = mem_wdata;
        pend.push_back(e);
        last_ack = e.ack_edge;
      end
    end
  end

  task automatic send(bit rd, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
    bit ok = 0;
    mem_req   = 1'b1;
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    mem_req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    mem_req = 1'b0;
    for (int i = 0; i < 3000 && pend.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (pend.size() > 0) check_eq("drain_timeout", pend.size(), 0);
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1;
    check_eq("rst_ready", mem_ready, 1);
    check_eq("rst_ack", mem_ack, 0);
    check_eq("rst_err", mem_err, 0);
    check_eq("rst_data", mem_data, 0);

    // Give every readable word a known value.
    for (int a = 0; a < ERR_BASE; a++) send(0, 1, AW'(a), $urandom);
    drain();

    send(0, 1, 8'd10, 32'hDEADBEEF);
    send(1, 0, 8'd10, '0);
    drain();
    check_eq("raw_model", model_mem[10], 32'hDEADBEEF);

    send(1, 0, 8'd100, '0);
    drain();

    send(1, 0, 8'd200, '0);
    send(0, 1, 8'd200, 32'h1234_5678);
    drain();

    saw_not_ready = 0;
    for (int a = 0; a < 6; a++) send(1, 0, AW'(a), '0);
    drain();
    check_eq("backpressure_seen", saw_not_ready, 1);

    send(1, 1, 8'd5, 32'hFFFF_0000);
    send(1, 0, 8'd5, '0);
    drain();

    send(0, 1, 8'd70, 32'hAAAA_0001);
    send(0, 1, 8'd71, 32'hAAAA_0002);
    send(0, 1, 8'd72, 32'hAAAA_0003);
    mem_req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("midrst_ready", mem_ready, 1);
    check_eq("midrst_pending", pend.size(), 0);
    idle(20);
    send(1, 0, 8'd70, '0);
    send(1, 0, 8'd71, '0);
    send(1, 0, 8'd72, '0);
    drain();

    for (int i = 0; i < 200; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 5)      send(1, 0, AW'($urandom_range(0, 255)), $urandom);
      else if (k < 9) send(0, 1, AW'($urandom_range(0, 255)), $urandom);
      else if (k == 9 && ($urandom_range(0, 1) == 0)) send(1, 1, AW'($urandom_range(0, 255)), $urandom);
      else            send(0, 0, AW'($urandom_range(0, 255)), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
